// File: rtl/axi4_mem_slave.sv
// AXI4 burst responder backed by a single-port on-chip RAM, serving one transaction at a time.
// Define AXI4_SLV_STALL_EN to add LFSR-driven back-pressure on W and R.
module axi4_mem_slave #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 30,
    parameter int ID_W    = 4,
    parameter int DEPTH_W = 10
) (
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [3:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    input  logic [3:0]          axi_awqos,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [3:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    input  logic [3:0]          axi_arqos,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   idx_q, idx_d;
    logic [3:0]           len_q, len_d, cnt_q, cnt_d;
    logic [1:0]           burst_q, burst_d, bresp_q, bresp_d;
    logic [ID_W-1:0]      bid_q, bid_d, rid_q, rid_d;
    logic                 idle_rdy_q, idle_rdy_d, wready_q, wready_d;
    logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                 err_q, err_d, rd_done_q, rd_done_d;
    logic [DATA_W-1:0]    rdata_q;
    logic [DATA_W-1:0]    mem [2**DEPTH_W];
    logic                 stall, aw_hs, ar_hs, w_hs, b_hs, r_hs, last_beat, w_err, fetch;
    logic [DEPTH_W-1:0]   next_idx;
    logic                 unused_ok;

`ifdef AXI4_SLV_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign stall  = (lfsr_q[1:0] == 2'b00);
    always_ff @(posedge axi_clk) begin
        if (axi_reset) lfsr_q <= 16'hACE1;
        else           lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign axi_awready = idle_rdy_q;
    assign axi_arready = idle_rdy_q & ~axi_awvalid;
    assign axi_wready  = wready_q & ~stall;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = 2'b00;

    assign aw_hs     = axi_awvalid & idle_rdy_q;
    assign ar_hs     = axi_arvalid & axi_arready;
    assign w_hs      = axi_wvalid & axi_wready;
    assign b_hs      = bvalid_q & axi_bready;
    assign r_hs      = rvalid_q & axi_rready;
    assign last_beat = (cnt_q == len_q);
    assign w_err     = err_q | (axi_wlast != last_beat);
    assign next_idx  = (burst_q == 2'b00) ? idx_q : idx_q + 1'b1;
    // Fetch only into an empty or draining output slot so a held beat never changes.
    assign fetch     = (state_q == RDATA) & ~rd_done_q & (~rvalid_q | axi_rready) & ~stall;

    assign unused_ok = ^{axi_awaddr, axi_araddr, axi_awsize, axi_arsize, axi_awlock, axi_arlock,
                         axi_awcache, axi_arcache, axi_awprot, axi_arprot, axi_awqos, axi_arqos};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        bresp_d    = bresp_q;
        bid_d      = bid_q;
        rid_d      = rid_q;
        idle_rdy_d = idle_rdy_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        err_d      = err_q;
        rd_done_d  = rd_done_q;
        case (state_q)
            IDLE: begin
                idle_rdy_d = 1'b1;
                if (aw_hs) begin
                    state_d    = WDATA;
                    idle_rdy_d = 1'b0;
                    wready_d   = 1'b1;
                    idx_d      = axi_awaddr[OFF +: DEPTH_W];
                    len_d      = axi_awlen;
                    burst_d    = axi_awburst;
                    cnt_d      = 4'd0;
                    err_d      = 1'b0;
                    bid_d      = axi_awid;
                end else if (ar_hs) begin
                    state_d    = RDATA;
                    idle_rdy_d = 1'b0;
                    idx_d      = axi_araddr[OFF +: DEPTH_W];
                    len_d      = axi_arlen;
                    burst_d    = axi_arburst;
                    cnt_d      = 4'd0;
                    rd_done_d  = 1'b0;
                    rid_d      = axi_arid;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    idx_d = next_idx;
                    cnt_d = cnt_q + 4'd1;
                    err_d = w_err;
                    // The awlen count ends the burst; wlast only feeds the error flag.
                    if (last_beat) begin
                        state_d  = WRESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = w_err ? 2'b10 : 2'b00;
                    end
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_d    = IDLE;
                    bvalid_d   = 1'b0;
                    idle_rdy_d = 1'b1;
                end
            end
            RDATA: begin
                if (fetch) begin
                    idx_d     = next_idx;
                    cnt_d     = cnt_q + 4'd1;
                    rvalid_d  = 1'b1;
                    rlast_d   = last_beat;
                    rd_done_d = last_beat;
                end else if (r_hs) begin
                    rvalid_d = 1'b0;
                end
                if (r_hs && rlast_q) begin
                    state_d    = IDLE;
                    rvalid_d   = 1'b0;
                    rlast_d    = 1'b0;
                    idle_rdy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= 4'd0;
            cnt_q      <= 4'd0;
            burst_q    <= 2'b00;
            bresp_q    <= 2'b00;
            bid_q      <= '0;
            rid_q      <= '0;
            idle_rdy_q <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
            rid_q      <= rid_d;
            idle_rdy_q <= idle_rdy_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            err_q      <= err_d;
            rd_done_q  <= rd_done_d;
        end
    end

    // RAM contents survive reset; only the read output register is cleared.
    always_ff @(posedge axi_clk) begin
        if (w_hs && !axi_reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset)  rdata_q <= '0;
        else if (fetch) rdata_q <= mem[idx_q];
    end
endmodule
